// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch stage of the naive-mips pipeline.
//
// Generates sequential, branch and flush PCs, runs a req/ack handshake with the
// instruction memory and presents {if_pc, if_inst, if_valid} to the IF/ID
// register, freezing them while the pipeline is stalled.
//
// Configuration macro:
//   IF_DELAY_SLOT_EN  defined   -> MIPS branch delay slot: the sequential
//                                  instruction after a branch is delivered
//                                  before the fetch is redirected.
//                     undefined -> branches redirect at once and the in-flight
//                                  sequential instruction is discarded.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous reset, active low
//   stall            IF/ID cannot accept; hold a valid output
//   flush            exception/eret redirect to new_pc, highest priority
//   new_pc           flush target
//   branch_flag_i    taken branch/jump resolved in ID
//   branch_target_i  branch target
//   inst_req         fetch request to instruction memory
//   inst_addr        fetch address, stable while inst_req is high
//   inst_ack         memory returns inst_rdata this cycle
//   inst_rdata       fetched instruction
//   if_pc            PC of the delivered instruction
//   if_inst          delivered instruction
//   if_valid         if_pc/if_inst are valid
module pc_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);

`ifdef IF_DELAY_SLOT_EN
  localparam bit DelaySlotEn = 1'b1;
`else
  localparam bit DelaySlotEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;          // address of the current/next fetch
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [DATA_W-1:0]   if_inst_q, if_inst_d;
  logic                if_valid_q, if_valid_d;
  logic                pend_vld_q, pend_vld_d;  // redirect waiting for the outstanding ack
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic                ds_pend_q, ds_pend_d;    // next delivered instruction is a delay slot

  logic                accept;
  logic                hold_out;
  logic                new_branch;
  logic [ADDR_W-1:0]   flush_pc;
  logic [ADDR_W-1:0]   branch_pc;
  logic [ADDR_W-1:0]   seq_pc;

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  assign accept     = req_q & inst_ack;
  assign hold_out   = if_valid_q & stall;
  // A branch arriving while a redirect is already pending loses to it.
  assign new_branch = branch_flag_i & ~pend_vld_q;
  assign flush_pc   = new_pc & AlignMask;
  assign branch_pc  = branch_target_i & AlignMask;
  assign seq_pc     = pc_q + ADDR_W'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    ds_pend_d  = ds_pend_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        req_d   = 1'b1;
        if (flush) begin
          pc_d = flush_pc;
        end else if (new_branch) begin
          if (DelaySlotEn) begin
            // The sequential fetch at pc is the delay slot; redirect after it.
            pend_vld_d = 1'b1;
            pend_pc_d  = branch_pc;
            ds_pend_d  = 1'b1;
          end else begin
            pc_d = branch_pc;
          end
        end
      end

      StReq: begin
        if (flush) begin
          if_valid_d = 1'b0;
          ds_pend_d  = 1'b0;
          if (accept) begin
            pc_d       = flush_pc;
            pend_vld_d = 1'b0;
          end else begin
            // Request cannot be withdrawn; overwrite any pending branch target.
            pend_vld_d = 1'b1;
            pend_pc_d  = flush_pc;
          end
        end else if (hold_out) begin
          // Output must stay frozen: ignore any ack and refetch pc after the stall.
          state_d = StHold;
          req_d   = 1'b0;
          if (new_branch) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = branch_pc;
            ds_pend_d  = DelaySlotEn;
          end
        end else if (accept) begin
          if (pend_vld_q) begin
            // Delay-slot data is kept; data fetched before a plain redirect is dropped.
            pc_d       = pend_pc_q;
            pend_vld_d = 1'b0;
            ds_pend_d  = 1'b0;
            if_valid_d = ds_pend_q;
            if (ds_pend_q) begin
              if_pc_d   = pc_q;
              if_inst_d = inst_rdata;
            end
          end else if (branch_flag_i) begin
            pc_d       = branch_pc;
            if_valid_d = DelaySlotEn;
            if (DelaySlotEn) begin
              if_pc_d   = pc_q;
              if_inst_d = inst_rdata;
            end
          end else begin
            pc_d       = seq_pc;
            if_pc_d    = pc_q;
            if_inst_d  = inst_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          if_valid_d = 1'b0;
          if (new_branch) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = branch_pc;
            ds_pend_d  = DelaySlotEn;
          end
        end
      end

      StHold: begin
        if (flush) begin
          state_d    = StReq;
          req_d      = 1'b1;
          if_valid_d = 1'b0;
          pc_d       = flush_pc;
          pend_vld_d = 1'b0;
          ds_pend_d  = 1'b0;
        end else if (stall) begin
          if (new_branch) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = branch_pc;
            ds_pend_d  = DelaySlotEn;
          end
        end else begin
          state_d    = StReq;
          req_d      = 1'b1;
          if_valid_d = 1'b0;
          if (pend_vld_q && !ds_pend_q) begin
            pc_d       = pend_pc_q;
            pend_vld_d = 1'b0;
          end else if (new_branch) begin
            if (DelaySlotEn) begin
              pend_vld_d = 1'b1;
              pend_pc_d  = branch_pc;
              ds_pend_d  = 1'b1;
            end else begin
              pc_d = branch_pc;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= RESET_PC;
      ds_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      ds_pend_q  <= ds_pend_d;
    end
  end

  assign inst_req  = req_q;
  assign inst_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch. Inputs change and outputs are sampled on the
// falling clock edge; memory data is a fixed function of the fetch address.
module tb_pc_fetch;

  localparam logic [31:0] RstPc = 32'hBFC0_0000;
  localparam logic [31:0] Salt  = 32'h5A5A_0000;

`ifdef IF_DELAY_SLOT_EN
  localparam logic DsEn = 1'b1;
`else
  localparam logic DsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  assign inst_rdata = inst_addr ^ Salt;

  pc_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_ack        (inst_ack),
    .inst_rdata      (inst_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic req);
    check({tag, "_req"}, {31'b0, inst_req}, {31'b0, req});
    check({tag, "_addr"}, inst_addr, addr);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    check({tag, "_vld"}, {31'b0, if_valid}, 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_inst"}, if_inst, pc ^ Salt);
  endtask

  task automatic chk_vld(input string tag, input logic vld);
    check({tag, "_vld"}, {31'b0, if_valid}, {31'b0, vld});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    new_pc          = '0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    inst_ack        = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk_fetch("rst", RstPc, 1'b0);
    chk_vld("rst", 1'b0);
    check("rst_pc", if_pc, RstPc);
    check("rst_inst", if_inst, 32'h0);
    tick();
    chk_fetch("rst_hold", RstPc, 1'b0);

    // 1: sequential stream with a 0-wait memory
    rst      = 1'b1;
    inst_ack = 1'b1;
    tick();
    chk_fetch("t1_first", RstPc, 1'b1);
    chk_vld("t1_first", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fetch("t1_seq", RstPc + 32'(4 * (i + 1)), 1'b1);
      chk_out("t1_seq", RstPc + 32'(4 * i));
    end

    // 2: stall for three cycles while BFC00008 is presented
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fetch("t2_hold", RstPc + 32'hC, 1'b0);
      chk_out("t2_hold", RstPc + 32'h8);
    end
    stall = 1'b0;
    tick();
    chk_fetch("t2_rel", RstPc + 32'hC, 1'b1);
    chk_vld("t2_rel", 1'b0);
    tick();
    chk_out("t2_next", RstPc + 32'hC);
    chk_fetch("t2_next", RstPc + 32'h10, 1'b1);

    // 3: slow memory, branch to an unaligned target during the wait
    inst_ack        = 1'b0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_1002;
    tick();
    chk_fetch("t3_w1", RstPc + 32'h10, 1'b1);
    chk_vld("t3_w1", 1'b0);
    branch_flag_i = 1'b0;
    tick();
    chk_fetch("t3_w2", RstPc + 32'h10, 1'b1);
    inst_ack = 1'b1;
    tick();
    chk_vld("t3_ack", DsEn);
    chk_fetch("t3_ack", 32'h8000_1000, 1'b1);
    tick();
    chk_out("t3_tgt", 32'h8000_1000);
    chk_fetch("t3_tgt", 32'h8000_1004, 1'b1);

    // 4: flush and branch together; flush wins
    flush           = 1'b1;
    new_pc          = 32'h8000_0180;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_2000;
    tick();
    chk_fetch("t4_flush", 32'h8000_0180, 1'b1);
    chk_vld("t4_flush", 1'b0);
    flush         = 1'b0;
    branch_flag_i = 1'b0;
    tick();
    chk_out("t4_deliv", 32'h8000_0180);

    // 5: sequential wrap at the top of the address space
    flush  = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    tick();
    chk_fetch("t5_top", 32'hFFFF_FFFC, 1'b1);
    flush = 1'b0;
    tick();
    chk_out("t5_top", 32'hFFFF_FFFC);
    chk_fetch("t5_wrap", 32'h0000_0000, 1'b1);

    // 6: branch at 80000010 while 80000014 is in flight
    flush  = 1'b1;
    new_pc = 32'h8000_0010;
    tick();
    flush = 1'b0;
    tick();
    chk_out("t6_br", 32'h8000_0010);
    chk_fetch("t6_ds", 32'h8000_0014, 1'b1);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h8000_0100;
    tick();
    chk_vld("t6_ds", DsEn);
    chk_fetch("t6_tgt", 32'h8000_0100, 1'b1);
    branch_flag_i = 1'b0;
    tick();
    chk_out("t6_tgt", 32'h8000_0100);

    // 7: flush under stall, then stall with no valid output held
    stall  = 1'b1;
    flush  = 1'b1;
    new_pc = 32'h8000_0200;
    tick();
    chk_vld("t7_flush", 1'b0);
    chk_fetch("t7_flush", 32'h8000_0200, 1'b1);
    flush = 1'b0;
    tick();
    chk_out("t7_first", 32'h8000_0200);
    chk_fetch("t7_first", 32'h8000_0204, 1'b1);
    tick();
    chk_out("t7_hold", 32'h8000_0200);
    chk_fetch("t7_hold", 32'h8000_0204, 1'b0);
    stall = 1'b0;
    tick();
    chk_fetch("t7_rel", 32'h8000_0204, 1'b1);
    chk_vld("t7_rel", 1'b0);

    // 8: reset in the middle of a handshake
    inst_ack = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk_fetch("t8_rst", RstPc, 1'b0);
    chk_vld("t8_rst", 1'b0);
    inst_ack = 1'b1;
    @(negedge clk);
    chk_fetch("t8_ign", RstPc, 1'b0);
    chk_vld("t8_ign", 1'b0);
    rst = 1'b1;
    tick();
    chk_fetch("t8_idle", RstPc, 1'b1);
    chk_vld("t8_idle", 1'b0);
    tick();
    chk_out("t8_deliv", RstPc);
    chk_fetch("t8_deliv", RstPc + 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
